// File: rtl/lsu_if.sv
// CPU-side request/response and memory-side port bundle for the load/store unit.
// The slave modport is the LSU's view; the master modport drives it (CPU plus memory).
interface lsu_if #(
    parameter int AW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;
    logic [1:0]    rsp_cause;

    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
    logic [31:0]   rdata;
    logic          rd_valid;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rdata, rd_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_cause,
               ren, wen, addr, wdata, wmask
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rdata, rd_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_cause,
               ren, wen, addr, wdata, wmask
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time, alignment/funct3 checking,
// byte-lane store steering, load formatting, bounded load wait and fault counting.
module lsu #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_if.slave       bus,
    output logic [7:0] fault_cnt
);
    typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state_reg,     state_next;
    logic [AW-1:0] addr_reg,      addr_next;
    logic [31:0]   wdata_reg,     wdata_next;
    logic [3:0]    wmask_reg,     wmask_next;
    logic [2:0]    funct3_reg,    funct3_next;
    logic          we_reg,        we_next;
    logic [7:0]    cnt_reg,       cnt_next;
    logic [31:0]   rdata_reg,     rdata_next;
    logic [1:0]    cause_reg,     cause_next;
    logic [7:0]    fault_cnt_reg, fault_cnt_next;

    logic [1:0]  req_off;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  req_cause;
    logic [3:0]  req_mask;
    logic [31:0] lane;
    logic [31:0] load_fmt;

    // Request decode; a store to address 0 is reported like a misalignment.
    always_comb begin
        req_off = bus.req_addr[1:0];
        if (bus.req_we) begin
            illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111);
        end
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && req_off[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (req_off != 2'b00)) ||
                     (bus.req_we && (bus.req_addr == '0));
        req_cause = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
        req_mask  = 4'b0000;
        if (bus.req_we) begin
            case (bus.req_funct3[1:0])
                2'b00:   req_mask = 4'b0001 << req_off;
                2'b01:   req_mask = req_off[1] ? 4'b1100 : 4'b0011;
                2'b10:   req_mask = 4'b1111;
                default: req_mask = 4'b0000;
            endcase
        end
    end

    // Pick the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        lane     = bus.rdata >> {addr_reg[1:0], 3'b000};
        load_fmt = lane;
        case (funct3_reg[1:0])
            2'b00:   load_fmt = {{24{~funct3_reg[2] & lane[7]}}, lane[7:0]};
            2'b01:   load_fmt = {{16{~funct3_reg[2] & lane[15]}}, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wmask_next     = wmask_reg;
        funct3_next    = funct3_reg;
        we_next        = we_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        cause_next     = cause_reg;
        fault_cnt_next = fault_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_next   = bus.req_addr;
                    wdata_next  = bus.req_wdata << {req_off, 3'b000};
                    wmask_next  = req_mask;
                    funct3_next = bus.req_funct3;
                    we_next     = bus.req_we;
                    cnt_next    = 8'd0;
                    rdata_next  = 32'd0;
                    cause_next  = req_cause;
                    if (req_cause != 2'b00) begin
                        state_next = RESP;
                    end else if (bus.req_we) begin
                        state_next = STORE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            STORE: state_next = RESP;
            LOAD: begin
                // Data arriving on the final allowed cycle still beats the timeout.
                if (bus.rd_valid) begin
                    rdata_next = load_fmt;
                    state_next = RESP;
                end else if (cnt_reg == WAIT_LAST) begin
                    cause_next = 2'b10;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
                if ((cause_reg != 2'b00) && (fault_cnt_reg != 8'hFF)) begin
                    fault_cnt_next = fault_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            wmask_reg     <= 4'd0;
            funct3_reg    <= 3'd0;
            we_reg        <= 1'b0;
            cnt_reg       <= 8'd0;
            rdata_reg     <= 32'd0;
            cause_reg     <= 2'd0;
            fault_cnt_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wmask_reg     <= wmask_next;
            funct3_reg    <= funct3_next;
            we_reg        <= we_next;
            cnt_reg       <= cnt_next;
            rdata_reg     <= rdata_next;
            cause_reg     <= cause_next;
            fault_cnt_reg <= fault_cnt_next;
        end
    end

    assign bus.req_ready = rst_n && (state_reg == IDLE);
    assign bus.ren       = (state_reg == LOAD);
    assign bus.wen       = (state_reg == STORE) && we_reg;
    assign bus.addr      = addr_reg;
    assign bus.wdata     = wdata_reg;
    assign bus.wmask     = wmask_reg;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_rdata = (state_reg == RESP) ? rdata_reg : 32'd0;
    assign bus.rsp_fault = (state_reg == RESP) && (cause_reg != 2'b00);
    assign bus.rsp_cause = (state_reg == RESP) ? cause_reg : 2'b00;
    assign fault_cnt     = fault_cnt_reg;
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes reference-model expectations, a
// negedge monitor pops them on each response and checks the memory side.
module tb_lsu;
    localparam int AW = 16;
    localparam int TO = 4;

    typedef struct {
        logic [31:0]   rdata;
        logic          fault;
        logic [1:0]    cause;
        int            lat;
        int            acc;
        int            nren;
        int            nwen;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fault_cnt;

    lsu_if #(.AW(AW)) bus ();

    lsu #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fault_cnt (fault_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   ren_cnt = 0;
    int   wen_cnt = 0;
    int   model_fcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: outcome of one access from the architectural rules.
    function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [AW-1:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd, input int n);
        exp_t e;
        int off, sz;
        bit illegal, misal;
        longint unsigned v, lim, rd64;
        e.rdata = 0; e.fault = 0; e.cause = 0; e.lat = 0; e.acc = 0;
        e.nren = 0; e.nwen = 0; e.addr = a; e.wdata = 0; e.wmask = 0;
        off = int'(a % 4);
        sz  = 1 << f3[1:0];
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misal   = ((off % sz) != 0) || (we && a == 0);
        if (illegal) begin
            e.cause = 2'd3; e.lat = 1;
        end else if (misal) begin
            e.cause = 2'd1; e.lat = 1;
        end else if (we) begin
            e.lat = 2; e.nwen = 1;
            e.wdata = wd << (8 * off);
            e.wmask = 4'(((1 << sz) - 1) << off);
        end else if (n < TO) begin
            e.lat  = 2 + n;
            e.nren = n + 1;
            rd64 = {32'd0, rd};
            lim  = 64'd1 << (8 * sz);
            v    = (rd64 >> (8 * off)) % lim;
            if (!f3[2] && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
            e.rdata = v[31:0];
        end else begin
            e.cause = 2'd2; e.lat = TO + 1; e.nren = TO;
        end
        e.fault = (e.cause != 0);
        return e;
    endfunction

    // One access; called at a negedge while the DUT is idle, returns at the
    // negedge after the response when the unit is idle again.
    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int n);
        exp_t e;
        e = model(we, f3, a, wd, rd, n);
        e.acc = cyc;
        sb.push_back(e);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.rd_valid   = 1'($urandom);
        bus.rdata      = $urandom;
        for (int j = 1; j <= e.lat + 1; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.req_valid  = 1'b0;
                bus.req_we     = 1'($urandom);
                bus.req_funct3 = 3'($urandom);
                bus.req_addr   = AW'($urandom);
                bus.req_wdata  = $urandom;
            end
            bus.rdata    = $urandom;
            bus.rd_valid = 1'($urandom);
            if (j <= e.nren) begin
                bus.rd_valid = (j - 1 == n);
                if (j - 1 == n) bus.rdata = rd;
            end
        end
        if (e.fault && model_fcnt < 255) model_fcnt++;
        chk("fault_cnt", fault_cnt, model_fcnt);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ren_cnt = 0;
                wen_cnt = 0;
            end else begin
                chk("ren_wen_exclusive", bus.ren & bus.wen, 0);
                if (bus.wen) begin
                    wen_cnt++;
                    chk("wen_addr_nonzero", (bus.addr != 0), 1);
                    if (sb.size() > 0) begin
                        chk("store_addr", bus.addr, sb[0].addr);
                        chk("store_wdata", bus.wdata, sb[0].wdata);
                        chk("store_wmask", bus.wmask, sb[0].wmask);
                    end
                end
                if (bus.ren) begin
                    ren_cnt++;
                    if (sb.size() > 0) chk("load_addr", bus.addr, sb[0].addr);
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                        chk("rsp_fault", bus.rsp_fault, e.fault);
                        chk("rsp_cause", bus.rsp_cause, e.cause);
                        chk("rsp_latency", cyc - e.acc, e.lat);
                        chk("ren_cycles", ren_cnt, e.nren);
                        chk("wen_cycles", wen_cnt, e.nwen);
                        chk("req_ready_busy", bus.req_ready, 0);
                    end
                    ren_cnt = 0;
                    wen_cnt = 0;
                end else begin
                    chk("rsp_idle_zero", {bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause}, 0);
                end
                if (sb.size() > 0 && (cyc - sb[0].acc) > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing: got no response after %0d cycles, expected one", cyc - sb[0].acc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [AW-1:0] a;
        logic [2:0]    f3;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.rdata = 0; bus.rd_valid = 0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_outputs", {bus.ren, bus.wen, bus.addr, bus.wdata, bus.wmask}, 0);
        chk("reset_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_fault, bus.rsp_cause}, 0);
        chk("reset_fault_cnt", fault_cnt, 0);
        rst_n = 1'b1;
        #1;

        // Directed cases
        do_txn(0, 3'b100, 16'h0103, 32'h0, 32'h80AA55CC, 0);   // LBU
        do_txn(0, 3'b001, 16'h0002, 32'h0, 32'h80011234, 3);   // LH after 3 waits
        do_txn(1, 3'b000, 16'h0011, 32'h12345678, 32'h0, 0);   // SB
        do_txn(0, 3'b010, 16'h0006, 32'h0, 32'h0, 0);          // misaligned LW
        do_txn(0, 3'b111, 16'h0008, 32'h0, 32'h0, 0);          // illegal load
        do_txn(0, 3'b010, 16'h0020, 32'h0, 32'hDEADBEEF, TO);  // timeout
        do_txn(0, 3'b010, 16'h0020, 32'h0, 32'hCAFEF00D, TO - 1); // data on last cycle
        do_txn(1, 3'b010, 16'h0000, 32'h11111111, 32'h0, 0);   // store to 0
        do_txn(1, 3'b011, 16'h0000, 32'h11111111, 32'h0, 0);   // illegal store to 0
        do_txn(1, 3'b001, 16'h0042, 32'hA5A5BEEF, 32'h0, 0);   // SH upper half
        do_txn(0, 3'b101, 16'h0042, 32'h0, 32'h9ABC0000, 1);   // LHU upper half

        // Reset in the middle of a load wait
        bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b010;
        bus.req_addr = 16'h0040; bus.rd_valid = 0;
        @(negedge clk);
        bus.req_valid = 0; bus.rd_valid = 0;
        chk("ren_before_reset", bus.ren, 1);
        @(negedge clk);
        bus.rd_valid = 0;
        @(negedge clk);
        bus.rd_valid = 0;
        rst_n = 1'b0;
        #1;
        model_fcnt = 0;
        chk("abort_ren", bus.ren, 0);
        chk("abort_outputs", {bus.wen, bus.addr, bus.rsp_valid, bus.req_ready}, 0);
        chk("abort_fault_cnt", fault_cnt, 0);
        repeat (2) begin
            @(negedge clk);
            bus.rd_valid = 1'($urandom);
            chk("abort_no_rsp", {bus.rsp_valid, bus.req_ready}, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", bus.req_ready, 1);
        do_txn(0, 3'b000, 16'h0081, 32'h0, 32'h00007F00, 2);   // LB after reset

        // Randomized accesses
        for (int i = 0; i < 300; i++) begin
            f3 = 3'($urandom);
            a  = AW'($urandom);
            if ($urandom_range(0, 2) > 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                else if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) a = '0;
            do_txn(1'($urandom), f3, a, $urandom, $urandom, $urandom_range(0, TO + 1));
        end

        // Drive the fault counter into saturation
        for (int i = 0; i < 260; i++) begin
            do_txn(0, 3'b110, AW'($urandom), 32'h0, 32'h0, 0);
        end
        chk("fault_cnt_saturated", fault_cnt, 255);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
